// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator. Produces column/row
//               counters, registered H/V sync pulses with programmable
//               polarity, an active-video flag and line/frame start strobes.
//               All flags are decoded from the next-state counts so they are
//               aligned with the registered counters in the same cycle.
//               Optional feature macro: VGA_TIMING_FRAME_COUNT_EN adds a
//               16-bit o_Frame_Count output.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int ACTIVE_COLS   = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_WIDTH  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int ACTIVE_ROWS   = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_WIDTH  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter bit HSYNC_POL     = 1'b0,
    parameter bit VSYNC_POL     = 1'b0,
    parameter int COUNT_WIDTH   = 10
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Enable,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic                   o_Active,
    output logic                   o_Line_Start,
    output logic                   o_Frame_Start,
    output logic [COUNT_WIDTH-1:0] o_Col_Count,
    output logic [COUNT_WIDTH-1:0] o_Row_Count
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [15:0]            o_Frame_Count
`endif
);

    localparam int c_TOTAL_COLS = ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int c_TOTAL_ROWS = ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
    localparam int c_HS_START   = ACTIVE_COLS + H_FRONT_PORCH;
    localparam int c_HS_END     = c_HS_START + H_SYNC_WIDTH;
    localparam int c_VS_START   = ACTIVE_ROWS + V_FRONT_PORCH;
    localparam int c_VS_END     = c_VS_START + V_SYNC_WIDTH;

    // Count-width versions of the decode boundaries. Because back porches are
    // at least one, every boundary below fits in COUNT_WIDTH bits.
    localparam logic [COUNT_WIDTH-1:0] c_COL_LAST   = COUNT_WIDTH'(c_TOTAL_COLS - 1);
    localparam logic [COUNT_WIDTH-1:0] c_ROW_LAST   = COUNT_WIDTH'(c_TOTAL_ROWS - 1);
    localparam logic [COUNT_WIDTH-1:0] c_ACT_COLS   = COUNT_WIDTH'(ACTIVE_COLS);
    localparam logic [COUNT_WIDTH-1:0] c_ACT_ROWS   = COUNT_WIDTH'(ACTIVE_ROWS);
    localparam logic [COUNT_WIDTH-1:0] c_HS_START_W = COUNT_WIDTH'(c_HS_START);
    localparam logic [COUNT_WIDTH-1:0] c_HS_END_W   = COUNT_WIDTH'(c_HS_END);
    localparam logic [COUNT_WIDTH-1:0] c_VS_START_W = COUNT_WIDTH'(c_VS_START);
    localparam logic [COUNT_WIDTH-1:0] c_VS_END_W   = COUNT_WIDTH'(c_VS_END);

    // Reject timing modes that cannot be represented or that would make the
    // sync pulse touch the wrap point.
    generate
        if ((H_BACK_PORCH < 1) || (V_BACK_PORCH < 1) ||
            (H_SYNC_WIDTH < 1) || (V_SYNC_WIDTH < 1) ||
            (c_TOTAL_COLS > (1 << COUNT_WIDTH)) ||
            (c_TOTAL_ROWS > (1 << COUNT_WIDTH))) begin : g_bad_params
            $error("vga_timing_gen: illegal timing parameters");
        end
    endgenerate

    logic [COUNT_WIDTH-1:0] r_col;
    logic [COUNT_WIDTH-1:0] r_row;
    logic                   r_hsync;
    logic                   r_vsync;
    logic                   r_active;
    logic                   r_line_start;
    logic                   r_frame_start;

    logic                   w_col_wrap;
    logic [COUNT_WIDTH-1:0] w_col_next;
    logic [COUNT_WIDTH-1:0] w_row_next;
    logic                   w_hs_on;
    logic                   w_vs_on;
    logic                   w_active_next;
    logic                   w_line_next;
    logic                   w_frame_next;

    // Next position: column wraps at line end, row advances (and wraps) then
    assign w_col_wrap = (r_col == c_COL_LAST);
    assign w_col_next = w_col_wrap ? '0 : r_col + COUNT_WIDTH'(1);
    assign w_row_next = !w_col_wrap ? r_row :
                        ((r_row == c_ROW_LAST) ? '0 : r_row + COUNT_WIDTH'(1));

    // Decodes taken from the next position so they register alongside it
    assign w_hs_on       = (w_col_next >= c_HS_START_W) && (w_col_next < c_HS_END_W);
    assign w_vs_on       = (w_row_next >= c_VS_START_W) && (w_row_next < c_VS_END_W);
    assign w_active_next = (w_col_next < c_ACT_COLS) && (w_row_next < c_ACT_ROWS);
    assign w_line_next   = (w_col_next == '0);
    assign w_frame_next  = w_line_next && (w_row_next == '0);

    // Position and flag registers; reset parks on the last back-porch pixel
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_col         <= c_COL_LAST;
            r_row         <= c_ROW_LAST;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (i_Enable) begin
            r_col         <= w_col_next;
            r_row         <= w_row_next;
            r_hsync       <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
            r_active      <= w_active_next;
            r_line_start  <= w_line_next;
            r_frame_start <= w_frame_next;
        end
    end

    assign o_Col_Count   = r_col;
    assign o_Row_Count   = r_row;
    assign o_HSync       = r_hsync;
    assign o_VSync       = r_vsync;
    assign o_Active      = r_active;
    assign o_Line_Start  = r_line_start;
    assign o_Frame_Start = r_frame_start;

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    // Frame counter starts at all-ones so the first frame after reset reads 0
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_frame_count <= 16'hFFFF;
        end else if (i_Enable && w_frame_next) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign o_Frame_Count = r_frame_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed self-checking bench for vga_timing_gen. Instance d
//               uses the default 640x480 mode (reset values, one full line);
//               instance s uses a small 24x14 mode with active-high syncs so
//               whole frames, pixel-enable gating and mid-frame reset fit in
//               a short run.
//               Small mode: cols 0..15 active, HSync cols 18..20, total 24;
//                           rows 0..7 active, VSync rows 10..11, total 14.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en;

    logic       d_hs, d_vs, d_act, d_ls, d_fs;
    logic [9:0] d_col, d_row;
    logic       s_hs, s_vs, s_act, s_ls, s_fs;
    logic [9:0] s_col, s_row;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] d_fc, s_fc;
`endif

    int vectors     = 0;
    int miscompares = 0;

    vga_timing_gen u_d (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Enable      (en),
        .o_HSync       (d_hs),
        .o_VSync       (d_vs),
        .o_Active      (d_act),
        .o_Line_Start  (d_ls),
        .o_Frame_Start (d_fs),
        .o_Col_Count   (d_col),
        .o_Row_Count   (d_row)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        ,
        .o_Frame_Count (d_fc)
`endif
    );

    vga_timing_gen #(
        .ACTIVE_COLS   (16),
        .H_FRONT_PORCH (2),
        .H_SYNC_WIDTH  (3),
        .H_BACK_PORCH  (3),
        .ACTIVE_ROWS   (8),
        .V_FRONT_PORCH (2),
        .V_SYNC_WIDTH  (2),
        .V_BACK_PORCH  (2),
        .HSYNC_POL     (1'b1),
        .VSYNC_POL     (1'b1),
        .COUNT_WIDTH   (10)
    ) u_s (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Enable      (en),
        .o_HSync       (s_hs),
        .o_VSync       (s_vs),
        .o_Active      (s_act),
        .o_Line_Start  (s_ls),
        .o_Frame_Start (s_fs),
        .o_Col_Count   (s_col),
        .o_Row_Count   (s_row)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        ,
        .o_Frame_Count (s_fc)
`endif
    );

    // Sample 1 time unit after the rising edge; inputs change here too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int hs_cnt, hs_first, hs_last;
        int act_cnt, act_last, ls_cnt, fs_cnt;
        int vs_cnt, vs_first, vs_last;
        int period, hold_err;
        logic prev_fs;
        logic [9:0] before_col, before_row;

        // ---- Reset for 3 cycles with enable high: reset wins ----
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) tick();
        check("d_rst_col",   d_col, 799);
        check("d_rst_row",   d_row, 524);
        check("d_rst_hs",    d_hs, 1);
        check("d_rst_vs",    d_vs, 1);
        check("d_rst_act",   d_act, 0);
        check("d_rst_ls",    d_ls, 0);
        check("d_rst_fs",    d_fs, 0);
        check("s_rst_col",   s_col, 23);
        check("s_rst_row",   s_row, 13);
        check("s_rst_hs",    s_hs, 0);
        check("s_rst_vs",    s_vs, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        check("s_rst_fc",    s_fc, 16'hFFFF);
`endif

        // ---- First enabled edge lands on (0,0) with both strobes ----
        rst = 1'b0;
        tick();
        check("d_first_col", d_col, 0);
        check("d_first_row", d_row, 0);
        check("d_first_fs",  d_fs, 1);
        check("d_first_ls",  d_ls, 1);
        check("d_first_act", d_act, 1);
        check("d_first_hs",  d_hs, 1);
        check("s_first_fs",  s_fs, 1);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        check("s_first_fc",  s_fc, 0);
`endif

        // ---- One full default line on instance d ----
        hs_cnt = 0; hs_first = -1; hs_last = -1;
        act_cnt = 0; act_last = -1; ls_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (d_hs == 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(d_col);
                hs_last = int'(d_col);
            end
            if (d_act) begin
                act_cnt++;
                act_last = int'(d_col);
            end
            if (d_ls) ls_cnt++;
            tick();
        end
        check("d_hs_cycles", hs_cnt, 96);
        check("d_hs_first",  hs_first, 656);
        check("d_hs_last",   hs_last, 751);
        check("d_act_cycles", act_cnt, 640);
        check("d_act_last",  act_last, 639);
        check("d_ls_per_line", ls_cnt, 1);
        check("d_line2_col", d_col, 0);
        check("d_line2_row", d_row, 1);
        check("d_line2_ls",  d_ls, 1);
        check("d_line2_fs",  d_fs, 0);
        // 800 edges on a 24x14 raster: row 33 mod 14 = 5, col 8
        check("s_800_col",   s_col, 8);
        check("s_800_row",   s_row, 5);

        // ---- Reset mid-frame ----
        rst = 1'b1;
        tick();
        check("s_mid_rst_col", s_col, 23);
        check("s_mid_rst_row", s_row, 13);
        check("s_mid_rst_hs",  s_hs, 0);
        check("s_mid_rst_vs",  s_vs, 0);
        check("s_mid_rst_act", s_act, 0);
        check("s_mid_rst_ls",  s_ls, 0);
        check("d_mid_rst_col", d_col, 799);
        check("d_mid_rst_row", d_row, 524);
        rst = 1'b0;
        tick();
        check("s_restart_col", s_col, 0);
        check("s_restart_row", s_row, 0);
        check("s_restart_fs",  s_fs, 1);
        check("s_restart_act", s_act, 1);

        // ---- One full small frame, enable held high ----
        hs_cnt = 0; hs_first = -1; hs_last = -1;
        act_cnt = 0; act_last = -1; ls_cnt = 0; fs_cnt = 0;
        vs_cnt = 0; vs_first = -1; vs_last = -1;
        for (int i = 0; i < 336; i++) begin
            if (s_vs) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = int'(s_row);
                vs_last = int'(s_row);
            end
            if (s_hs) begin
                hs_cnt++;
                if (s_row == 10'd0) begin
                    if (hs_first < 0) hs_first = int'(s_col);
                    hs_last = int'(s_col);
                end
            end
            if (s_act) begin
                act_cnt++;
                act_last = int'(s_row);
            end
            if (s_ls) ls_cnt++;
            if (s_fs) fs_cnt++;
            tick();
        end
        check("s_vs_cycles",  vs_cnt, 48);
        check("s_vs_first",   vs_first, 10);
        check("s_vs_last",    vs_last, 11);
        check("s_hs_cycles",  hs_cnt, 42);
        check("s_hs_first",   hs_first, 18);
        check("s_hs_last",    hs_last, 20);
        check("s_act_cycles", act_cnt, 128);
        check("s_act_lastrow", act_last, 7);
        check("s_ls_per_frame", ls_cnt, 14);
        check("s_fs_per_frame", fs_cnt, 1);
        check("s_frame2_col", s_col, 0);
        check("s_frame2_row", s_row, 0);
        check("s_frame2_fs",  s_fs, 1);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        check("s_frame2_fc",  s_fc, 1);
`endif

        // ---- Enable alternating 0/1: frame period doubles in clocks ----
        period   = -1;
        prev_fs  = 1'b1;
        hold_err = 0;
        for (int k = 1; k <= 2000 && period < 0; k++) begin
            en = (k % 2 == 0);
            before_col = s_col;
            before_row = s_row;
            tick();
            if (!en && ((s_col != before_col) || (s_row != before_row))) hold_err++;
            if (k == 1) check("s_fs_held_disabled", s_fs, 1);
            if (k == 2) check("s_fs_drop_after_en", s_fs, 0);
            if (s_fs && !prev_fs) period = k;
            prev_fs = s_fs;
        end
        check("s_fs_period_clocks", period, 672);
        check("s_hold_errors", hold_err, 0);
        check("s_alt_col", s_col, 0);
        check("s_alt_row", s_row, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        check("s_alt_fc", s_fc, 2);
`endif
        en = 1'b0;
        tick();
        check("s_fs_held_end", s_fs, 1);
        check("s_col_held_end", s_col, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
